seq_gen_mode: RTL and testbench

Parametrised multi-mode sequence generator, successor to the fixed-width generator. It produces one W-bit value per accepted transfer in one of four modes: binary up, binary down, Gray, or Fibonacci LFSR. It adds a seed load, an enable, a valid/ready output handshake with backpressure, and a wrap qualifier. It feeds test-pattern and address-stimulus paths in the CPU datapath benches.

---
 rtl/seq_gen_mode.sv | 113 +++++++++++
 tb/tb_seq_gen_mode.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_gen_mode.sv
// Multi-mode W-bit sequence generator: binary up/down, Gray and Fibonacci LFSR.
// It has a seed load, a run enable and a registered valid/ready output with a wrap qualifier.
module seq_gen_mode #(
  parameter int          W    = 8,
  parameter logic [31:0] SEED = 32'd1,
  parameter logic [31:0] TAPS = 32'hB8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [1:0]   mode,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] seq_out,
  output logic         wrap
);

  // Handshake: a value is consumed on any rising edge where out_valid && out_ready.
  // seq_out and wrap stay stable while out_valid is high and out_ready is low.

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [W-1:0] SEED_W = SEED[W-1:0];
  localparam logic [W-1:0] TAPS_W = TAPS[W-1:0];
  localparam logic [W-1:0] ONE    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ONES   = '1;

  state_t       state, state_nxt;
  logic [W-1:0] b, b_nxt, seq_nxt, start_q, lfsr_src;
  logic [W-1:0] load_b, load_seq;
  logic         wrap_nxt;
  logic         xfer;

  function automatic logic [W-1:0] gray(input logic [W-1:0] v);
    return v ^ (v >> 1);
  endfunction

  assign out_valid = (state == RUN);
  assign xfer      = out_valid && out_ready;

  // Advance candidate for the mode sampled this cycle, always from the binary state b.
  always_comb begin
    lfsr_src = (b == '0) ? ONE : b;
    b_nxt    = b;
    seq_nxt  = b;
    wrap_nxt = 1'b0;
    case (mode)
      2'd0: begin
        b_nxt    = b + ONE;
        seq_nxt  = b_nxt;
        wrap_nxt = (b == ONES);
      end
      2'd1: begin
        b_nxt    = b - ONE;
        seq_nxt  = b_nxt;
        wrap_nxt = (b == '0);
      end
      2'd2: begin
        b_nxt    = b + ONE;
        seq_nxt  = gray(b_nxt);
        wrap_nxt = (b == ONES);
      end
      default: begin
        b_nxt    = {lfsr_src[W-2:0], ^(lfsr_src & TAPS_W)};
        seq_nxt  = b_nxt;
        wrap_nxt = (b_nxt == start_q);
      end
    endcase
  end

  // A zero seed would lock the LFSR, so it loads as one in that mode.
  always_comb begin
    load_b   = ((mode == 2'd3) && (seed == '0)) ? ONE : seed;
    load_seq = (mode == 2'd2) ? gray(seed) : load_b;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (en && !load) state_nxt = RUN;
      RUN: begin
        if (load)            state_nxt = IDLE;
        else if (xfer && !en) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      b       <= SEED_W;
      seq_out <= SEED_W;
      start_q <= SEED_W;
      wrap    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        b       <= load_b;
        seq_out <= load_seq;
        start_q <= load_b;
        wrap    <= 1'b0;
      end else if (xfer) begin
        b       <= b_nxt;
        seq_out <= seq_nxt;
        wrap    <= wrap_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seq_gen_mode.sv
// Bench for seq_gen_mode (W=8): directed scenarios followed by random stimulus,
// all checked against an integer reference model of the generator.
module tb_seq_gen_mode;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, en, load, out_ready;
  logic [1:0]   mode;
  logic [W-1:0] seed;
  logic         out_valid, wrap;
  logic [W-1:0] seq_out;

  int total = 0;
  int bad   = 0;

  // Reference model state, as plain integers.
  int m_b, m_seq, m_start;
  bit m_wrap, m_valid;

  // Scoreboard of consumed values: {wrap, seq_out} expected at each transfer.
  logic [W:0] exp_q[$];
  logic [W:0] exp_v;

  bit seen[256];
  int distinct, wraps;

  seq_gen_mode #(.W(W), .SEED(32'd1), .TAPS(32'hB8)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .seed(seed),
    .out_ready(out_ready), .out_valid(out_valid), .seq_out(seq_out), .wrap(wrap)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic int gray_of(input int v);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: one clock edge, using inputs held stable across the edge.
  task automatic model_step();
    int nb, s;
    bit xf;
    xf = m_valid && out_ready;
    if (rst) begin
      m_b = 1; m_seq = 1; m_start = 1; m_wrap = 0; m_valid = 0;
    end else if (load) begin
      m_b     = (mode == 2'd3 && seed == 0) ? 1 : int'(seed);
      m_seq   = (mode == 2'd2) ? gray_of(int'(seed)) : m_b;
      m_start = m_b;
      m_wrap  = 0;
      m_valid = 0;
    end else if (xf) begin
      case (mode)
        2'd0: begin nb = (m_b + 1) % 256;   m_wrap = (nb == 0);   m_seq = nb; end
        2'd1: begin nb = (m_b + 255) % 256; m_wrap = (nb == 255); m_seq = nb; end
        2'd2: begin nb = (m_b + 1) % 256;   m_wrap = (nb == 0);   m_seq = gray_of(nb); end
        default: begin
          s  = (m_b == 0) ? 1 : m_b;
          nb = ((s << 1) % 256) + ($countones(s & 'hB8) % 2);
          m_wrap = (nb == m_start);
          m_seq  = nb;
        end
      endcase
      m_b = nb;
      if (!en) m_valid = 0;
    end else if (!m_valid && en) begin
      m_valid = 1;
    end
  endtask

  // Driver tasks
  task automatic drive(input bit r, input bit e, input logic [1:0] m, input bit l,
                       input logic [W-1:0] s, input bit rd);
    rst = r; en = e; mode = m; load = l; seed = s; out_ready = rd;
  endtask

  task automatic tick();
    if (out_valid === 1'b1 && out_ready && exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      chk("xfer_value", {23'd0, wrap, seq_out}, {23'd0, exp_v});
    end
    @(posedge clk);
    model_step();
    #1;
    chk("model_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("model_seq",   {24'd0, seq_out},   m_seq);
    chk("model_wrap",  {31'd0, wrap},      {31'd0, m_wrap});
  endtask

  initial begin
    m_b = 1; m_seq = 1; m_start = 1; m_wrap = 0; m_valid = 0;

    // Reset, then binary up count through one full wrap.
    drive(1, 0, 2'd0, 0, 8'h00, 1);
    tick(); tick();
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_seq",   {24'd0, seq_out},   1);
    chk("rst_wrap",  {31'd0, wrap},      0);
    drive(0, 1, 2'd0, 0, 8'h00, 1);
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h02});
    exp_q.push_back({1'b0, 8'h03});
    tick();
    chk("first_valid", {31'd0, out_valid}, 1);
    chk("first_seq",   {24'd0, seq_out},   1);
    for (int i = 0; i < 255; i++) tick();
    chk("up_wrap_seq",  {24'd0, seq_out}, 0);
    chk("up_wrap_flag", {31'd0, wrap},    1);
    tick();
    chk("up_after_seq",  {24'd0, seq_out}, 1);
    chk("up_after_wrap", {31'd0, wrap},    0);

    // Backpressure at 0x10.
    for (int i = 0; i < 15; i++) tick();
    chk("bp_start", {24'd0, seq_out}, 8'h10);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_seq",   {24'd0, seq_out},   8'h10);
      chk("bp_hold_valid", {31'd0, out_valid}, 1);
    end
    out_ready = 1;
    tick();
    chk("bp_release", {24'd0, seq_out}, 8'h11);

    // Down count from a zero seed.
    drive(0, 1, 2'd1, 1, 8'h00, 1);
    tick();
    chk("dn_load_valid", {31'd0, out_valid}, 0);
    chk("dn_load_seq",   {24'd0, seq_out},   0);
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b1, 8'hFF});
    exp_q.push_back({1'b0, 8'hFE});
    load = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("dn_drained", exp_q.size(), 0);

    // Gray sequence from a zero seed, full cycle.
    drive(0, 1, 2'd2, 1, 8'h00, 1);
    tick();
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back({1'b0, 8'h00}); exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h03}); exp_q.push_back({1'b0, 8'h02});
    exp_q.push_back({1'b0, 8'h06}); exp_q.push_back({1'b0, 8'h07});
    exp_q.push_back({1'b0, 8'h05}); exp_q.push_back({1'b0, 8'h04});
    load = 0;
    tick();
    for (int i = 0; i < 256; i++) tick();
    chk("gray_drained",  exp_q.size(), 0);
    chk("gray_wrap_seq", {24'd0, seq_out}, 0);
    chk("gray_wrap",     {31'd0, wrap},    1);

    // LFSR: maximal-length cycle from seed 1.
    drive(0, 1, 2'd3, 1, 8'h01, 1);
    tick();
    load = 0;
    tick();
    chk("lfsr_first", {24'd0, seq_out}, 1);
    foreach (seen[i]) seen[i] = 0;
    distinct = 0; wraps = 0;
    for (int i = 0; i < 255; i++) begin
      tick();
      if (!seen[seq_out]) distinct++;
      seen[seq_out] = 1;
      if (wrap) begin
        wraps++;
        chk("lfsr_wrap_at_seed", {24'd0, seq_out}, 1);
      end
    end
    chk("lfsr_distinct", distinct, 255);
    chk("lfsr_no_zero",  {31'd0, seen[0]}, 0);
    chk("lfsr_wraps",    wraps, 1);
    chk("lfsr_end_seq",  {24'd0, seq_out}, 1);
    drive(0, 1, 2'd3, 1, 8'h00, 1);
    tick();
    chk("lfsr_seed0", {24'd0, seq_out}, 1);
    load = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("lfsr_nonzero", {31'd0, seq_out == 8'h00}, 0);
    end

    // Mid-run reset at 0x40.
    drive(0, 1, 2'd0, 1, 8'h3F, 1);
    tick();
    load = 0;
    tick(); tick();
    chk("mid_0x40", {24'd0, seq_out}, 8'h40);
    rst = 1;
    tick();
    chk("mid_rst_seq",   {24'd0, seq_out},   1);
    chk("mid_rst_valid", {31'd0, out_valid}, 0);
    rst = 0;
    tick();

    // Load beats a simultaneous transfer.
    exp_q.push_back({1'b0, 8'h01});
    drive(0, 1, 2'd0, 1, 8'hAA, 1);
    tick();
    chk("ldx_seq",   {24'd0, seq_out},   8'hAA);
    chk("ldx_valid", {31'd0, out_valid}, 0);
    chk("ldx_drain", exp_q.size(), 0);
    load = 0;
    tick();

    // en dropped under backpressure: value held until accepted, then idle.
    en = 0; out_ready = 0;
    tick(); tick();
    chk("en0_hold_valid", {31'd0, out_valid}, 1);
    chk("en0_hold_seq",   {24'd0, seq_out},   8'hAA);
    out_ready = 1;
    tick();
    chk("en0_idle_valid", {31'd0, out_valid}, 0);
    chk("en0_staged_seq", {24'd0, seq_out},   8'hAB);
    tick();
    chk("en0_stay_seq", {24'd0, seq_out}, 8'hAB);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      load      = ($urandom_range(0, 24) == 0);
      en        = ($urandom_range(0, 4) != 0);
      mode      = 2'($urandom_range(0, 3));
      seed      = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
